bram_copy_master: RTL and testbench

//  Avalon-MM master that copies a block of words within a dual-port BRAM
//  (src -> dst) on one BRAM port, freeing the CPU from word-by-word copies.

---
 rtl/bram_copy_pkg.sv | 20 ++
 rtl/bram_copy_master_if.sv | 38 +++
 rtl/bram_copy_master.sv | 167 ++++++++++++++++
 tb/tb_bram_copy_master.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_copy_pkg.sv
// Shared types and default sizing for the BRAM block-copy master.
package bram_copy_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH  = 12;
    localparam int unsigned DEF_BYTE_WIDTH     = 8;
    localparam int unsigned DEF_BYTES_PER_WORD = 4;
    localparam int unsigned DEF_READ_LATENCY   = 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // One BRAM word at the default geometry, byte-lane addressable.
    typedef logic [DEF_BYTES_PER_WORD-1:0][DEF_BYTE_WIDTH-1:0] word_t;

endpackage

// File: rtl/bram_copy_master_if.sv
// Avalon-MM word bus between the copy master and one BRAM port.
//   master: drives avm_address/avm_byteenable/avm_read/avm_write/avm_writedata,
//           receives avm_readdata
//   slave : the BRAM side of the same signals
interface bram_copy_master_if
    import bram_copy_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int unsigned BYTE_WIDTH     = DEF_BYTE_WIDTH,
    parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD
) ();

    logic [ADDRESS_WIDTH-1:0]                   avm_address;
    logic [BYTES_PER_WORD-1:0]                  avm_byteenable;
    logic                                       avm_read;
    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  avm_readdata;
    logic                                       avm_write;
    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  avm_writedata;

    modport master (
        output avm_address,
        output avm_byteenable,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_byteenable,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/bram_copy_master.sv
// Avalon-MM master copying a block of words src -> dst inside one BRAM port,
// one word at a time: READ, READ_LATENCY x WAIT, WRITE.
// Ports:
//   clock, reset_n       single clock, asynchronous active-low reset
//   start                one-cycle request, only honoured while idle
//   src_addr, dst_addr   first source / destination word address
//   length               word count (0 .. 2^ADDRESS_WIDTH)
//   busy, done           busy from the cycle after start through done; done pulses once
//   avm                  master side of the BRAM bus (bram_copy_master_if)
//   checksum             running 32-bit sum of copied words
//                        (present only with BRAM_COPY_CHECKSUM_EN defined)
// The interface instance must be parameterised with the same geometry.
module bram_copy_master
    import bram_copy_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int unsigned BYTE_WIDTH     = DEF_BYTE_WIDTH,
    parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int unsigned READ_LATENCY   = DEF_READ_LATENCY
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDRESS_WIDTH-1:0]   src_addr,
    input  logic [ADDRESS_WIDTH-1:0]   dst_addr,
    input  logic [ADDRESS_WIDTH:0]     length,
    output logic                       busy,
    output logic                       done,
    bram_copy_master_if.master         avm
`ifdef BRAM_COPY_CHECKSUM_EN
    ,
    output logic [31:0]                checksum
`endif
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned LW = ADDRESS_WIDTH + 1;
    localparam int unsigned CW = $clog2(READ_LATENCY + 1);

    typedef logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] bus_word_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             src_q, src_d;
    logic [AW-1:0]             dst_q, dst_d;
    logic [LW-1:0]             rem_q, rem_d;
    logic [CW-1:0]             wait_q, wait_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      rd_q, rd_d;
    logic                      wr_q, wr_d;
    logic [BYTES_PER_WORD-1:0] be_q, be_d;
    logic [AW-1:0]             addr_q, addr_d;
    bus_word_t                 wdata_q, wdata_d;
`ifdef BRAM_COPY_CHECKSUM_EN
    logic [31:0]               csum_q, csum_d;
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wait_d  = '0;
        wdata_d = wdata_q;
`ifdef BRAM_COPY_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = length;
`ifdef BRAM_COPY_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Last wait cycle: read data is valid now, capture it as the write word.
                if (wait_q == CW'(READ_LATENCY - 1)) begin
                    state_d = WRITE;
                    wdata_d = avm.avm_readdata;
                end else begin
                    wait_d  = wait_q + CW'(1);
                end
            end
            WRITE: begin
                src_d   = src_q + AW'(1);
                dst_d   = dst_q + AW'(1);
                rem_d   = rem_q - LW'(1);
`ifdef BRAM_COPY_CHECKSUM_EN
                csum_d  = csum_q + 32'(wdata_q);
`endif
                state_d = (rem_q == LW'(1)) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        rd_d   = (state_d == READ);
        wr_d   = (state_d == WRITE);
        be_d   = (rd_d || wr_d) ? '1 : '0;
        addr_d = rd_d ? src_d : (wr_d ? dst_d : '0);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef BRAM_COPY_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef BRAM_COPY_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = wdata_q;
`ifdef BRAM_COPY_CHECKSUM_EN
    assign checksum           = csum_q;
`endif

endmodule

// File: tb/tb_bram_copy_master.sv
// Bench for bram_copy_master against a read-latency-1 BRAM model.
// Optional checksum checks follow BRAM_COPY_CHECKSUM_EN.
module tb_bram_copy_master;
    import bram_copy_pkg::*;

    localparam int unsigned AW    = 12;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned BW    = 8;
    localparam int unsigned BPW   = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
`ifdef BRAM_COPY_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    always #5 clock = ~clock;

    bram_copy_master_if #(.ADDRESS_WIDTH(AW), .BYTE_WIDTH(BW), .BYTES_PER_WORD(BPW)) bus ();

    bram_copy_master #(
        .ADDRESS_WIDTH (AW),
        .BYTE_WIDTH    (BW),
        .BYTES_PER_WORD(BPW),
        .READ_LATENCY  (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .length  (length),
        .busy    (busy),
        .done    (done),
        .avm     (bus)
`ifdef BRAM_COPY_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    // BRAM model: registered read (latency 1), byte-enabled write, plus a load port.
    word_t         mem [DEPTH];
    word_t         rdata;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    word_t         ld_data;

    always @(posedge clock) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (bus.avm_write) begin
            for (int b = 0; b < BPW; b++)
                if (bus.avm_byteenable[b]) mem[bus.avm_address][b] <= bus.avm_writedata[b];
        end
        if (bus.avm_read) rdata <= mem[bus.avm_address];
    end
    assign bus.avm_readdata = rdata;

    // Reference memory and scoreboard.
    typedef struct packed {
        logic [AW-1:0] a;
        word_t         d;
    } wr_exp_t;

    word_t         shadow [DEPTH];
    logic [AW-1:0] rd_q [$];
    wr_exp_t       wr_q [$];
    logic [31:0]   exp_csum;
    int            n_checks;
    int            n_fail;
    int            done_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sample_bus();
        logic [AW-1:0] a;
        wr_exp_t       w;
        if (bus.avm_read || bus.avm_write) begin
            check("rd_wr_exclusive", 64'(bus.avm_read & bus.avm_write), 64'(0));
            check("byteenable_on", 64'(bus.avm_byteenable), 64'(4'hF));
        end else begin
            check("byteenable_off", 64'(bus.avm_byteenable), 64'(0));
        end
        if (bus.avm_read) begin
            check("rd_expected", 64'(rd_q.size() != 0), 64'(1));
            if (rd_q.size() != 0) begin
                a = rd_q.pop_front();
                check("rd_addr", 64'(bus.avm_address), 64'(a));
            end
        end
        if (bus.avm_write) begin
            check("wr_expected", 64'(wr_q.size() != 0), 64'(1));
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("wr_addr", 64'(bus.avm_address), 64'(w.a));
                check("wr_data", 64'(bus.avm_writedata), 64'(w.d));
            end
        end
        if (done) done_seen++;
    endtask

    task automatic tick();
        @(negedge clock);
        sample_bus();
    endtask

    task automatic preload(input logic [AW-1:0] a, input word_t d);
        @(negedge clock);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clock);
        #1 ld_en = 1'b0;
        shadow[a] = d;
    endtask

    // Forward copy on the reference memory; queue the bus traffic it implies.
    task automatic push_expect(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len);
        logic [AW-1:0] s;
        logic [AW-1:0] d;
        word_t         w;
        for (int i = 0; i < len; i++) begin
            s = src + AW'(i);
            d = dst + AW'(i);
            w = shadow[s];
            shadow[d] = w;
            rd_q.push_back(s);
            wr_q.push_back('{a: d, d: w});
            exp_csum = exp_csum + 32'(w);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_read"},  64'(bus.avm_read), 64'(0));
        check({tag, "_write"}, 64'(bus.avm_write), 64'(0));
        check({tag, "_be"},    64'(bus.avm_byteenable), 64'(0));
        check({tag, "_addr"},  64'(bus.avm_address), 64'(0));
        check({tag, "_wdata"}, 64'(bus.avm_writedata), 64'(0));
`ifdef BRAM_COPY_CHECKSUM_EN
        check({tag, "_csum"},  64'(checksum), 64'(0));
`endif
    endtask

    task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                            input bit repulse);
        int lat;
        logic [AW-1:0] a;
        exp_csum = '0;
        push_expect(src, dst, len);
        @(negedge clock);
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        length   = LW'(len);
        @(posedge clock);
        #1;
        start    = 1'b0;
        src_addr = ~src;
        dst_addr = ~dst;
        length   = LW'(len + 5);
        done_seen = 0;
        lat = 0;
        for (int c = 1; c <= len * 3 + 20; c++) begin
            tick();
            if (c == 1) check("busy_rise", 64'(busy), 64'(1));
            if (repulse && c == 4) begin
                start    = 1'b1;
                src_addr = AW'(700);
                dst_addr = AW'(800);
                length   = LW'(2);
            end
            if (repulse && c == 5) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        check("done_latency", 64'(lat), 64'(len * 3 + 1));
`ifdef BRAM_COPY_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(exp_csum));
`endif
        tick();
        check("busy_fall", 64'(busy), 64'(0));
        repeat (3) tick();
        check("done_pulses", 64'(done_seen), 64'(1));
        check("rd_q_drained", 64'(rd_q.size()), 64'(0));
        check("wr_q_drained", 64'(wr_q.size()), 64'(0));
        for (int i = 0; i < len; i++) begin
            a = dst + AW'(i);
            check($sformatf("mem[%0d]", a), 64'(mem[a]), 64'(shadow[a]));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done_seen = 0;
        exp_csum = '0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        reset_n  = 1'b1;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_quiet("reset");
        reset_n = 1'b1;

        // Basic four-word copy.
        preload(AW'(0), 32'd11);
        preload(AW'(1), 32'd22);
        preload(AW'(2), 32'd33);
        preload(AW'(3), 32'd44);
        run_copy(AW'(0), AW'(16), 4, 1'b0);

        // Zero length: immediate done, no bus traffic.
        run_copy(AW'(5), AW'(20), 0, 1'b0);

        // Source pointer wraps past the top of the address space.
        preload(AW'(4094), 32'hA5A5_0001);
        preload(AW'(4095), 32'hA5A5_0002);
        preload(AW'(0),    32'hA5A5_0003);
        run_copy(AW'(4094), AW'(10), 3, 1'b0);

        // Overlapping forward copy replicates the leading pattern.
        preload(AW'(50), 32'hDEAD_0050);
        preload(AW'(51), 32'hBEEF_0051);
        run_copy(AW'(50), AW'(52), 6, 1'b0);

        // Second start while busy must be ignored.
        preload(AW'(60), 32'h0000_1060);
        preload(AW'(61), 32'h0000_1061);
        preload(AW'(62), 32'h0000_1062);
        run_copy(AW'(60), AW'(70), 3, 1'b1);

        // Reset right after the second write lands: copy aborted, two words written.
        for (int i = 0; i < 4; i++) preload(AW'(100 + i), 32'h0100_0000 + 32'(i));
        for (int i = 0; i < 4; i++) preload(AW'(200 + i), 32'h0200_0000 + 32'(i));
        exp_csum = '0;
        push_expect(AW'(100), AW'(200), 2);
        @(negedge clock);
        start    = 1'b1;
        src_addr = AW'(100);
        dst_addr = AW'(200);
        length   = LW'(4);
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 check_quiet("abort");
        tick();
        tick();
        reset_n = 1'b1;
        check("abort_rd_q", 64'(rd_q.size()), 64'(0));
        check("abort_wr_q", 64'(wr_q.size()), 64'(0));
        for (int i = 0; i < 4; i++)
            check($sformatf("abort_mem[%0d]", 200 + i), 64'(mem[200 + i]), 64'(shadow[200 + i]));
        run_copy(AW'(100), AW'(200), 4, 1'b0);

`ifdef BRAM_COPY_CHECKSUM_EN
        // Checksum wraps modulo 2^32.
        preload(AW'(300), 32'd1);
        preload(AW'(301), 32'd2);
        preload(AW'(302), 32'd3);
        preload(AW'(303), 32'hFFFF_FFFF);
        run_copy(AW'(300), AW'(400), 4, 1'b0);
        check("checksum_wrap", 64'(checksum), 64'(5));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
